muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide controller for the EX stage; owns the HI/LO registers.
//  Runs one operation over WIDTH+1 cycles: WIDTH shift-add/restoring steps plus one fix-up cycle.
//  Raises stall_req to the hazard logic in two cases:
//   - a MFHI/MFLO in ID while an operation runs
//   - a new mult/div start while one is already running
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH bits each; step counter is clog2(WIDTH) bits
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      ID/EX holds a MULT/MULTU/DIV/DIVU this cycle
//  op         in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV (op[1]=div, op[0]=signed)
//  rs_val     in   WIDTH  multiplicand / dividend
//  rt_val     in   WIDTH  multiplier / divisor
//  hilo_read  in   1      instruction in IF/ID is MFHI or MFLO
//  flush      in   1      abort the in-flight operation (branch/jump squash)
//  busy       out  1      state != IDLE
//  stall_req  out  1      combinational: busy & (hilo_read | start)
//  done       out  1      one-cycle pulse; HI/LO updated on the same edge
//  hi         out  WIDTH  HI register (product upper half / remainder)
//  lo         out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; hi=lo=0; done=0; counter, accumulators and operand regs = 0.
//  FSM states: IDLE, MUL, DIV, FIX.
//   - IDLE, start=1, flush=0 at edge E0: latch operands and signs; count=0; go MUL (op[1]=0) or DIV (op[1]=1).
//   - MUL/DIV: one step per edge; after WIDTH steps (edge E0+WIDTH) go FIX.
//   - FIX (edge E0+WIDTH+1): apply sign correction; write hi/lo; done<=1; go IDLE.
//  Latency: busy high WIDTH+1 cycles (33 by default). done and the new hi/lo are visible in the first IDLE cycle.
//  done is registered and is cleared on every edge where FIX is not the current state.
//  MUL: 2*WIDTH-bit product; hi=product[2W-1:W], lo=product[W-1:0].
//  DIV: restoring algorithm; lo=quotient, hi=remainder.
//  Divide by zero is not trapped; it falls out of the restoring algorithm:
//   - unsigned: lo=all ones, hi=rs_val.
//  Start while busy: not accepted, stall_req=1; the requester holds start until busy drops.
//  Start in the cycle done=1: accepted (state is IDLE).
//  flush: synchronous; in MUL/DIV/FIX go IDLE next edge; hi/lo unchanged; no done pulse.
//  flush and start in the same IDLE cycle: flush wins; nothing is accepted.
//  hilo_read while IDLE (including the done cycle): stall_req=0, hi/lo readable directly.
//  rst_n asserted mid-operation: immediate IDLE, outputs take their reset values; the operation is lost.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined:
//   - op[0]=1 runs the unit on |rs|,|rt|.
//   - FIX negates the product or quotient when the operand signs differ.
//   - FIX gives the remainder the sign of the dividend.
//   - Signed divide by zero: hi=rs_val; lo=FFFFFFFF if rs>=0, else 00000001.
//   - Most-negative / -1: lo=80000000, hi=0.
//  MULDIV_SIGNED_EN undefined:
//   - op[0] ignored; all ops unsigned; no sign logic synthesized.
//   - FIX only copies accumulators to hi/lo.
// TESTING
//  MULTU 7*6 -> busy high 33 cycles, then done pulses once; hi=0, lo=42.
//  DIVU 100/7 -> after 33 busy cycles lo=14, hi=2; back-to-back start in the done cycle accepted.
//  hilo_read=1 during MULTU -> stall_req=1 every busy cycle; stall_req=0 in the done cycle.
//  DIVU 0x1234/0 -> lo=FFFFFFFF, hi=00001234.
//  flush at busy cycle 10 -> busy=0 next cycle; hi/lo keep old values; done never pulses.
//  MULDIV_SIGNED_EN defined:
//   - MULT -3*5 -> hi=FFFFFFFF, lo=FFFFFFF1.
//   - DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//   - With the macro undefined, the same ops give unsigned results.
//  rst_n=0 at busy cycle 5 -> busy, done, hi, lo all 0 before the next clock edge.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: WIDTH shift-add / restoring steps plus one fix-up cycle.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV (op[0]); otherwise every op is unsigned.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hilo_read,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] acc_reg, mq_reg, opb_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             done_reg;
  logic             accept;
  logic [WIDTH-1:0] a_in, b_in;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             unused_msb;

  assign accept = (state_reg == IDLE) && start && !flush;

`ifdef MULDIV_SIGNED_EN
  logic sign_a_reg, sign_b_reg, is_div_reg;
  logic neg_a, neg_b;

  assign neg_a = op[0] & rs_val[WIDTH-1];
  assign neg_b = op[0] & rt_val[WIDTH-1];
  assign a_in  = neg_a ? -rs_val : rs_val;
  assign b_in  = neg_b ? -rt_val : rt_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      is_div_reg <= 1'b0;
    end else if (accept) begin
      sign_a_reg <= neg_a;
      sign_b_reg <= neg_b;
      is_div_reg <= op[1];
    end
  end
`else
  logic unused_op0;

  assign unused_op0 = op[0];
  assign a_in       = rs_val;
  assign b_in       = rt_val;
`endif

  // MUL step: add multiplicand on multiplier LSB, shift {acc,mq} right one bit.
  assign mul_sum = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, opb_reg} : '0);

  // DIV step: shift the next dividend bit into the partial remainder; restore on borrow.
  assign div_shift  = {acc_reg, mq_reg[WIDTH-1]};
  assign div_diff   = div_shift - {1'b0, opb_reg};
  assign div_ok     = ~div_diff[WIDTH];
  assign unused_msb = div_shift[WIDTH];

  always_comb begin
    fix_hi = acc_reg;
    fix_lo = mq_reg;
`ifdef MULDIV_SIGNED_EN
    if (is_div_reg) begin
      if (sign_a_reg ^ sign_b_reg) fix_lo = -mq_reg;
      if (sign_a_reg)              fix_hi = -acc_reg;
    end else if (sign_a_reg ^ sign_b_reg) begin
      {fix_hi, fix_lo} = -{acc_reg, mq_reg};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = op[1] ? DIV : MUL;
      MUL, DIV: begin
        if (flush)                             state_next = IDLE;
        else if (count_reg == CW'(WIDTH - 1))  state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    stall_req = busy & (hilo_read | start);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      mq_reg    <= '0;
      opb_reg   <= '0;
      count_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= (state_reg == FIX) && !flush;
      if (accept) begin
        acc_reg   <= '0;
        mq_reg    <= a_in;
        opb_reg   <= b_in;
        count_reg <= '0;
      end else begin
        case (state_reg)
          MUL: begin
            {acc_reg, mq_reg} <= {mul_sum, mq_reg[WIDTH-1:1]};
            count_reg         <= count_reg + CW'(1);
          end
          DIV: begin
            acc_reg   <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            mq_reg    <= {mq_reg[WIDTH-2:0], div_ok};
            count_reg <= count_reg + CW'(1);
          end
          FIX: begin
            if (!flush) begin
              hi_reg <= fix_hi;
              lo_reg <= fix_lo;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
